// File: rtl/video_pkg.sv
// Shared video constants and write-FSM state encoding for LCD framebuffer logic.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package video_pkg;

    localparam int LCD_WIDTH  = 160;
    localparam int LCD_HEIGHT = 144;
    // Four 2-bit shade codes per byte.
    localparam int FB_BYTES   = LCD_WIDTH * LCD_HEIGHT / 4;
    localparam int FB_ADDR_W  = $clog2(FB_BYTES);

    typedef enum logic {
        FBW_IDLE = 1'b0,
        FBW_REQ  = 1'b1
    } fbw_state_t;

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Pixel-stream input plus framebuffer write port of the LCD frame writer.
// Latency: none (wiring only).
// Backpressure: fb_wr_ack from the memory side stalls the writer's request.
interface lcd_frame_writer_if #(
    parameter int ADDR_W  = 13,
    parameter int LEVEL_W = 3
);
    logic [1:0]         pixel_data;
    logic               pixel_latch;
    logic               vsync;
    logic [ADDR_W-1:0]  fb_addr;
    logic [7:0]         fb_data;
    logic               fb_wr_req;
    logic               fb_wr_ack;
    logic               frame_done;
    logic               overflow;
    logic               overflow_clr;
    logic [LEVEL_W-1:0] fifo_level;

    // Writer side: consumes pixels, drives memory writes.
    modport master (
        input  pixel_data, pixel_latch, vsync, fb_wr_ack, overflow_clr,
        output fb_addr, fb_data, fb_wr_req, frame_done, overflow, fifo_level
    );

    // Environment side: video controller plus framebuffer memory.
    modport slave (
        output pixel_data, pixel_latch, vsync, fb_wr_ack, overflow_clr,
        input  fb_addr, fb_data, fb_wr_req, frame_done, overflow, fifo_level
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock circular FIFO with full/empty/level; head is read combinationally.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int IDX_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr[IDX_W-1:0]];

    // Storage and pointer update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[IDX_W-1:0]] <= push_data;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Packs 2-bit LCD pixels four per byte and writes them to the framebuffer through a FIFO.
// Latency: fb_wr_req rises two cycles after the 4th pixel latch (from empty/idle).
// Backpressure: fb_wr_ack stalls the head; bytes arriving while the FIFO is full are dropped and flagged.
module lcd_frame_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_BYTES   = video_pkg::FB_BYTES,
    parameter int ADDR_W     = video_pkg::FB_ADDR_W
) (
    input logic              clock,
    input logic              reset_n,
    lcd_frame_writer_if.master bus
);
    import video_pkg::*;

    localparam int                LEVEL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } fb_entry_t;

    logic              vsync_d;
    logic [1:0]        pack_cnt;
    logic [5:0]        pack_byte;
    logic [ADDR_W-1:0] wr_ptr_addr;
    logic              resync;
    logic [1:0]        cnt_eff;
    logic [ADDR_W-1:0] addr_eff;
    logic              push;
    logic              pop;
    logic              drop;
    fb_entry_t         push_entry;
    fb_entry_t         head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LEVEL_W-1:0] level;
    fbw_state_t        state;
    fbw_state_t        state_nxt;
    logic              frame_done_q;
    logic              overflow_q;

    // A resync in the same cycle as a latch takes effect first, so that
    // pixel becomes lane 0 of address 0.
    assign resync     = bus.vsync & ~vsync_d;
    assign cnt_eff    = resync ? 2'd0 : pack_cnt;
    assign addr_eff   = resync ? '0 : wr_ptr_addr;
    assign push       = bus.pixel_latch & (cnt_eff == 2'd3);
    assign push_entry = '{addr: addr_eff, data: {pack_byte, bus.pixel_data}};
    assign pop        = (state == FBW_REQ) & bus.fb_wr_ack;
    assign drop       = push & fifo_full & ~pop;

    // Packer: collect lanes MSB-first and advance the byte address on every completed byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d     <= 1'b0;
            pack_cnt    <= 2'd0;
            pack_byte   <= '0;
            wr_ptr_addr <= '0;
        end else begin
            vsync_d <= bus.vsync;
            if (resync) begin
                pack_cnt    <= 2'd0;
                pack_byte   <= '0;
                wr_ptr_addr <= '0;
            end
            if (bus.pixel_latch) begin
                pack_cnt <= cnt_eff + 2'd1;
                case (cnt_eff)
                    2'd0:    pack_byte[5:4] <= bus.pixel_data;
                    2'd1:    pack_byte[3:2] <= bus.pixel_data;
                    2'd2:    pack_byte[1:0] <= bus.pixel_data;
                    default: wr_ptr_addr    <= (addr_eff == LAST_ADDR) ? '0 : addr_eff + 1'b1;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Write FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FBW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next state: leave REQ only when the acked entry was the last one and nothing arrives.
    always_comb begin
        state_nxt = state;
        case (state)
            FBW_IDLE: begin
                if (!fifo_empty) state_nxt = FBW_REQ;
            end
            FBW_REQ: begin
                if (bus.fb_wr_ack && (level == LEVEL_W'(1)) && !push) state_nxt = FBW_IDLE;
            end
            default: state_nxt = FBW_IDLE;
        endcase
    end

    // Frame-done pulse after the last byte of a frame is acked; sticky overflow where set beats clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= pop && (head_entry.addr == LAST_ADDR);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.fb_wr_req  = (state == FBW_REQ);
    assign bus.fb_addr    = head_entry.addr;
    assign bus.fb_data    = head_entry.data;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: stimulus queues expected writes, a monitor checks them.
// Latency: checks the two-cycle request latency and back-to-back throughput.
// Backpressure: drives ack low/high patterns, overflow, resync and async reset.
module tb_lcd_frame_writer;
    import video_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LEVEL_W = 3;
    localparam int ADDR_W  = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lcd_frame_writer_if #(.ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W)) bus();

    lcd_frame_writer #(
        .FIFO_DEPTH (DEPTH),
        .FB_BYTES   (FB_BYTES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   tests      = 0;
    int   fails      = 0;
    int   fd_count   = 0;
    logic pending_fd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic latch(input logic [1:0] v);
        bus.pixel_data  = v;
        bus.pixel_latch = 1'b1;
        step();
        bus.pixel_latch = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        latch(b[7:6]);
        latch(b[5:4]);
        latch(b[3:2]);
        latch(b[1:0]);
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic resync_pulse();
        bus.vsync = 1'b1;
        step();
        bus.vsync = 1'b0;
        step();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || bus.fb_wr_req) && n < bound) begin
            step();
            n++;
        end
        check("drain_in_time", {31'd0, n < bound}, 32'd1);
    endtask

    // Monitor: every accepted write must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pending_fd = 1'b0;
            end else begin
                if (bus.frame_done || pending_fd) check("frame_done", {31'd0, bus.frame_done}, {31'd0, pending_fd});
                if (bus.frame_done) fd_count++;
                pending_fd = 1'b0;
                if (bus.fb_wr_req && bus.fb_wr_ack) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write was required", bus.fb_addr, bus.fb_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", {19'd0, bus.fb_addr}, {19'd0, mon_e.addr});
                        check("wr_data", {24'd0, bus.fb_data}, {24'd0, mon_e.data});
                    end
                    pending_fd = (bus.fb_addr == ADDR_W'(FB_BYTES - 1));
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat_ack [7];
        int pat_req [7];
        int pat_addr[7];
        int pat_data[7];
        int fd_before;

        pat_ack  = '{1, 0, 0, 1, 0, 1, 0};
        pat_req  = '{1, 1, 1, 1, 1, 1, 0};
        pat_addr = '{0, 1, 1, 1, 2, 2, 0};
        pat_data = '{8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h0F, 8'h0F, 0};

        bus.pixel_data   = 2'd0;
        bus.pixel_latch  = 1'b0;
        bus.vsync        = 1'b0;
        bus.fb_wr_ack    = 1'b0;
        bus.overflow_clr = 1'b0;

        // Reset state.
        @(negedge clock);
        check("rst_req",      {31'd0, bus.fb_wr_req}, 32'd0);
        check("rst_level",    {29'd0, bus.fifo_level}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_done",     {31'd0, bus.frame_done}, 32'd0);
        check("rst_addr",     {19'd0, bus.fb_addr}, 32'd0);
        check("rst_data",     {24'd0, bus.fb_data}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Single byte 3,2,1,0 -> 0xE4 at address 0 with two-cycle request latency.
        bus.fb_wr_ack = 1'b1;
        expect_wr(13'd0, 8'hE4);
        send_byte(8'hE4);
        @(negedge clock);
        check("t1_level_n1", {29'd0, bus.fifo_level}, 32'd1);
        check("t1_req_n1",   {31'd0, bus.fb_wr_req}, 32'd0);
        step();
        @(negedge clock);
        check("t1_req_n2",   {31'd0, bus.fb_wr_req}, 32'd1);
        step();
        @(negedge clock);
        check("t1_req_n3",   {31'd0, bus.fb_wr_req}, 32'd0);
        check("t1_level_n3", {29'd0, bus.fifo_level}, 32'd0);

        // Overflow: five bytes into a four-entry FIFO with ack held low.
        bus.fb_wr_ack = 1'b0;
        step();
        resync_pulse();
        expect_wr(13'd0, 8'h1B);
        expect_wr(13'd1, 8'h6C);
        expect_wr(13'd2, 8'hB1);
        expect_wr(13'd3, 8'hC6);
        send_byte(8'h1B);
        send_byte(8'h6C);
        send_byte(8'hB1);
        send_byte(8'hC6);
        send_byte(8'hFF);
        step();
        @(negedge clock);
        check("t2_level_full", {29'd0, bus.fifo_level}, 32'd4);
        check("t2_overflow",   {31'd0, bus.overflow}, 32'd1);
        check("t2_req_held",   {31'd0, bus.fb_wr_req}, 32'd1);
        check("t2_head_addr",  {19'd0, bus.fb_addr}, 32'd0);
        check("t2_head_data",  {24'd0, bus.fb_data}, 32'h1B);
        step();
        bus.overflow_clr = 1'b1;
        step();
        bus.overflow_clr = 1'b0;
        @(negedge clock);
        check("t2_ovf_cleared", {31'd0, bus.overflow}, 32'd0);
        // A clear coinciding with a fresh drop leaves the flag set.
        latch(2'd3);
        latch(2'd3);
        latch(2'd3);
        bus.overflow_clr = 1'b1;
        latch(2'd3);
        bus.overflow_clr = 1'b0;
        @(negedge clock);
        check("t2_set_wins", {31'd0, bus.overflow}, 32'd1);
        step();
        bus.fb_wr_ack = 1'b1;
        drain(40);
        @(negedge clock);
        check("t2_level_empty", {29'd0, bus.fifo_level}, 32'd0);

        // Vsync discards a partial byte; latch in the resync cycle lands at address 0.
        step();
        resync_pulse();
        expect_wr(13'd0, 8'h12);
        send_byte(8'h12);
        latch(2'd3);
        latch(2'd3);
        expect_wr(13'd0, 8'h55);
        bus.vsync = 1'b1;
        send_byte(8'h55);
        bus.vsync = 1'b0;
        drain(40);

        // Ack pattern 1,0,0,1,0,1 against three queued bytes.
        bus.fb_wr_ack = 1'b0;
        step();
        resync_pulse();
        expect_wr(13'd0, 8'hA5);
        expect_wr(13'd1, 8'h3C);
        expect_wr(13'd2, 8'h0F);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h0F);
        step();
        @(negedge clock);
        check("t5_req_ready", {31'd0, bus.fb_wr_req}, 32'd1);
        check("t5_level",     {29'd0, bus.fifo_level}, 32'd3);
        for (int i = 0; i < 7; i++) begin
            step();
            bus.fb_wr_ack = pat_ack[i][0];
            @(negedge clock);
            check("t5_req", {31'd0, bus.fb_wr_req}, pat_req[i]);
            if (pat_req[i] != 0) begin
                check("t5_addr", {19'd0, bus.fb_addr}, pat_addr[i]);
                check("t5_data", {24'd0, bus.fb_data}, pat_data[i]);
            end
        end

        // Full frame with ack high, then wrap to address 0 without vsync.
        step();
        bus.fb_wr_ack = 1'b1;
        resync_pulse();
        fd_before = fd_count;
        for (int a = 0; a < FB_BYTES; a++) begin
            expect_wr(ADDR_W'(a), 8'(a * 7 + 3));
            send_byte(8'(a * 7 + 3));
        end
        drain(50);
        step();
        step();
        check("t3_one_frame_done", fd_count - fd_before, 32'd1);
        expect_wr(13'd0, 8'h3C);
        send_byte(8'h3C);
        drain(40);
        step();
        check("t3_no_extra_done", fd_count - fd_before, 32'd1);

        // Asynchronous reset in the middle of an outstanding request.
        bus.fb_wr_ack = 1'b0;
        resync_pulse();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h66);
        step();
        @(negedge clock);
        check("t6_pre_req", {31'd0, bus.fb_wr_req}, 32'd1);
        check("t6_pre_ovf", {31'd0, bus.overflow}, 32'd1);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_req_async",   {31'd0, bus.fb_wr_req}, 32'd0);
        check("t6_level_async", {29'd0, bus.fifo_level}, 32'd0);
        check("t6_ovf_async",   {31'd0, bus.overflow}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        bus.fb_wr_ack = 1'b1;
        expect_wr(13'd0, 8'h9C);
        send_byte(8'h9C);
        drain(40);

        step();
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
